// File: rtl/contador_pkg.sv
// Shared constants and helpers for the counter/comparator datapath.
// Optional feature macro used by the top: CONTADOR_SATURA_EN.
package contador_pkg;

    // Direction encoding for the desce input.
    localparam logic DIR_UP   = 1'b0;
    localparam logic DIR_DOWN = 1'b1;

    // Clamp a parallel-load value into the legal count range 0..modulo-1.
    function automatic logic [31:0] clamp_carga(input logic [31:0] valor,
                                                input logic [31:0] modulo);
        logic [31:0] res;
        res = valor;
        if (valor >= modulo) begin
            res = modulo - 32'd1;
        end
        return res;
    endfunction

endpackage

// File: rtl/comparador_n.sv
// WIDTH-bit unsigned magnitude comparator with cascade inputs.
// When A==B the result is taken from the cascade inputs, so a stand-alone
// instance is tied to albi=0, agbi=0, aebi=1.
module comparador_n #(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             albi,
    input  logic             agbi,
    input  logic             aebi,
    output logic             alb,
    output logic             agb,
    output logic             aeb
);

    // Magnitude decision; equal operands defer to the cascade inputs.
    always_comb begin
        alb = 1'b0;
        agb = 1'b0;
        aeb = 1'b0;
        if (a < b) begin
            alb = 1'b1;
        end else if (a > b) begin
            agb = 1'b1;
        end else begin
            alb = albi;
            agb = agbi;
            aeb = aebi;
        end
    end

endmodule

// File: rtl/contador_comparador_n.sv
// WIDTH-bit up/down modulo counter with clear/load, a reference register,
// magnitude compare of count vs reference, terminal count and a sticky
// "reached" flag.
// Optional feature macro: CONTADOR_SATURA_EN (saturate instead of wrap).
module contador_comparador_n
    import contador_pkg::*;
#(
    parameter int WIDTH  = 4,
    parameter int MODULO = 16
) (
    input  logic             clock,
    input  logic             clr,
    input  logic             zera,
    input  logic             carrega,
    input  logic             conta,
    input  logic             desce,
    input  logic             carrega_ref,
    input  logic [WIDTH-1:0] chaves,
    output logic             menor,
    output logic             maior,
    output logic             igual,
    output logic             fim,
    output logic             atingiu,
    output logic [WIDTH-1:0] db_contagem,
    output logic [WIDTH-1:0] db_referencia
);

    localparam logic [WIDTH-1:0] MAX_Q = WIDTH'(MODULO - 1);

    logic [WIDTH-1:0] contagem;
    logic [WIDTH-1:0] contagem_next;
    logic [WIDTH-1:0] referencia;
    logic             no_topo;
    logic             no_fundo;

    assign no_topo  = (contagem == MAX_Q);
    assign no_fundo = (contagem == '0);

    // Next count: zera > carrega > conta > hold; boundary handling is wrap
    // by default and hold when saturation is built in.
    always_comb begin
        contagem_next = contagem;
        if (zera) begin
            contagem_next = '0;
        end else if (carrega) begin
            contagem_next = WIDTH'(clamp_carga(32'(chaves), 32'(MODULO)));
        end else if (conta) begin
            if (desce == DIR_DOWN) begin
                if (no_fundo) begin
`ifdef CONTADOR_SATURA_EN
                    contagem_next = '0;
`else
                    contagem_next = MAX_Q;
`endif
                end else begin
                    contagem_next = contagem - 1'b1;
                end
            end else begin
                if (no_topo) begin
`ifdef CONTADOR_SATURA_EN
                    contagem_next = MAX_Q;
`else
                    contagem_next = '0;
`endif
                end else begin
                    contagem_next = contagem + 1'b1;
                end
            end
        end
    end

    // Count register.
    always_ff @(posedge clock or negedge clr) begin
        if (!clr) begin
            contagem <= '0;
        end else begin
            contagem <= contagem_next;
        end
    end

    // Reference register: loads raw chaves, independent of counter priority.
    always_ff @(posedge clock or negedge clr) begin
        if (!clr) begin
            referencia <= '0;
        end else if (carrega_ref) begin
            referencia <= chaves;
        end
    end

    // Sticky "reached": set on an edge that sees igual, zera has priority.
    always_ff @(posedge clock or negedge clr) begin
        if (!clr) begin
            atingiu <= 1'b0;
        end else if (zera) begin
            atingiu <= 1'b0;
        end else if (igual) begin
            atingiu <= 1'b1;
        end
    end

    comparador_n #(
        .WIDTH(WIDTH)
    ) u_comparador (
        .a    (contagem),
        .b    (referencia),
        .albi (1'b0),
        .agbi (1'b0),
        .aebi (1'b1),
        .alb  (menor),
        .agb  (maior),
        .aeb  (igual)
    );

    // Terminal count follows the current direction, gated by conta.
    assign fim = conta & ((desce == DIR_DOWN) ? no_fundo : no_topo);

    assign db_contagem   = contagem;
    assign db_referencia = referencia;

endmodule

// File: tb/tb_contador_comparador_n.sv
// Table-driven bench for contador_comparador_n (WIDTH=4).
// Default build uses MODULO=10 with wrap; with CONTADOR_SATURA_EN it uses
// MODULO=16 and the saturation vectors.
module tb_contador_comparador_n;

    localparam int WIDTH = 4;
`ifdef CONTADOR_SATURA_EN
    localparam int MODULO = 16;
`else
    localparam int MODULO = 10;
`endif

    logic             clock;
    logic             clr;
    logic             zera;
    logic             carrega;
    logic             conta;
    logic             desce;
    logic             carrega_ref;
    logic [WIDTH-1:0] chaves;
    logic             menor;
    logic             maior;
    logic             igual;
    logic             fim;
    logic             atingiu;
    logic [WIDTH-1:0] db_contagem;
    logic [WIDTH-1:0] db_referencia;

    int n_cmp;
    int n_err;

    typedef struct packed {
        logic       zera;
        logic       carrega;
        logic       conta;
        logic       desce;
        logic       carrega_ref;
        logic [3:0] chaves;
        logic [3:0] e_q;
        logic [3:0] e_r;
        logic       e_menor;
        logic       e_maior;
        logic       e_igual;
        logic       e_fim;
        logic       e_atingiu;
    } vec_t;

    vec_t vecs[32];
    int   n_vecs;

    contador_comparador_n #(
        .WIDTH (WIDTH),
        .MODULO(MODULO)
    ) dut (
        .clock        (clock),
        .clr          (clr),
        .zera         (zera),
        .carrega      (carrega),
        .conta        (conta),
        .desce        (desce),
        .carrega_ref  (carrega_ref),
        .chaves       (chaves),
        .menor        (menor),
        .maior        (maior),
        .igual        (igual),
        .fim          (fim),
        .atingiu      (atingiu),
        .db_contagem  (db_contagem),
        .db_referencia(db_referencia)
    );

    // Clock
    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Compare one value and log any difference.
    task automatic check_val(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Compare every output against an expected set.
    task automatic check_all(input string tag, input logic [3:0] e_q, input logic [3:0] e_r,
                             input logic e_m, input logic e_mm, input logic e_i,
                             input logic e_f, input logic e_a);
        check_val({tag, ".contagem"},   32'(db_contagem),   32'(e_q));
        check_val({tag, ".referencia"}, 32'(db_referencia), 32'(e_r));
        check_val({tag, ".menor"},      32'(menor),         32'(e_m));
        check_val({tag, ".maior"},      32'(maior),         32'(e_mm));
        check_val({tag, ".igual"},      32'(igual),         32'(e_i));
        check_val({tag, ".fim"},        32'(fim),           32'(e_f));
        check_val({tag, ".atingiu"},    32'(atingiu),       32'(e_a));
    endtask

    // Drive one cycle of inputs at the falling edge; outputs are sampled at
    // the following falling edge with the same inputs still applied.
    task automatic drive(input logic z, input logic cg, input logic ct,
                         input logic d, input logic cr, input logic [3:0] ch);
        zera        = z;
        carrega     = cg;
        conta       = ct;
        desce       = d;
        carrega_ref = cr;
        chaves      = ch;
        @(posedge clock);
        @(negedge clock);
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;

`ifdef CONTADOR_SATURA_EN
        // z, cg, ct, d, cr, ch | q, r, menor, maior, igual, fim, atingiu
        vecs[0] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'd14, 4'd14, 4'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
        vecs[1] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'd0,  4'd15, 4'd0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
        vecs[2] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'd0,  4'd15, 4'd0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
        vecs[3] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'd0,  4'd15, 4'd0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
        vecs[4] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 4'd1,  4'd1,  4'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
        vecs[5] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 4'd0,  4'd0,  4'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
        vecs[6] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 4'd0,  4'd0,  4'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
        n_vecs = 7;
`else
        // z, cg, ct, d, cr, ch | q, r, menor, maior, igual, fim, atingiu
        vecs[0]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0,  4'd0, 4'd0,  1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[1]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 4'd5,  4'd0, 4'd5,  1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[2]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'd3,  4'd3, 4'd5,  1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[3]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'd0,  4'd4, 4'd5,  1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[4]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'd0,  4'd5, 4'd5,  1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[5]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'd0,  4'd6, 4'd5,  1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
        vecs[6]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'd0,  4'd7, 4'd5,  1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
        vecs[7]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'd0,  4'd8, 4'd5,  1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
        vecs[8]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'd0,  4'd9, 4'd5,  1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
        vecs[9]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'd0,  4'd0, 4'd5,  1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
        vecs[10] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 4'd7,  4'd0, 4'd5,  1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[11] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 4'd0,  4'd9, 4'd5,  1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[12] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 4'hF,  4'd9, 4'd5,  1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[13] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 4'd1,  4'd1, 4'd5,  1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[14] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 4'd0,  4'd0, 4'd5,  1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
        vecs[15] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 4'd0,  4'd9, 4'd5,  1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[16] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 4'hC,  4'd9, 4'd12, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[17] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 4'd9,  4'd9, 4'd9,  1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[18] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0,  4'd9, 4'd9,  1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
        vecs[19] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'd0,  4'd0, 4'd9,  1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
        vecs[20] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'd0,  4'd1, 4'd9,  1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
        n_vecs = 21;
`endif

        // Reset asserted from time zero, counting down enabled.
        clr         = 1'b0;
        zera        = 1'b0;
        carrega     = 1'b0;
        conta       = 1'b1;
        desce       = 1'b1;
        carrega_ref = 1'b0;
        chaves      = '0;
        #2;
        check_all("reset", 4'd0, 4'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        @(negedge clock);
        check_all("reset_edge", 4'd0, 4'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        clr = 1'b1;

        // Table vectors
        for (int i = 0; i < n_vecs; i++) begin
            drive(vecs[i].zera, vecs[i].carrega, vecs[i].conta, vecs[i].desce,
                  vecs[i].carrega_ref, vecs[i].chaves);
            check_all($sformatf("vec%0d", i), vecs[i].e_q, vecs[i].e_r, vecs[i].e_menor,
                      vecs[i].e_maior, vecs[i].e_igual, vecs[i].e_fim, vecs[i].e_atingiu);
        end

        // Asynchronous clear mid-count at Q=7, visible before any edge.
        drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'd7);
        check_val("mid_clr.pre_q", 32'(db_contagem), 32'd7);
        carrega = 1'b0;
        conta   = 1'b1;
        desce   = 1'b1;
        #2;
        clr = 1'b0;
        #1;
        check_all("mid_clr", 4'd0, 4'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        @(negedge clock);
        check_all("mid_clr_held", 4'd0, 4'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        clr = 1'b1;

        // zera + carrega + conta together at Q=6 with atingiu set.
        drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'd6);
        check_all("zc_load6", 4'd6, 4'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 4'd2);
        check_all("zc_ref2", 4'd6, 4'd2, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
        drive(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 4'd3);
        check_all("zc_all", 4'd0, 4'd2, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    // Global time limit so the run always ends.
    initial begin
        #100000;
        $display("FAIL timeout: run did not complete, got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
